rambus_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter placed in front of the rambus SRAM block.
- Lets the spell core (master 0) and a host-side Wishbone/LA bridge (master 1) share a single rambus port.
- Uses round-robin grants, holds each grant for the whole cycle, and runs a watchdog that aborts hung transfers and reports them with an error pulse.

---
 rtl/rambus_arbiter.sv | 159 +++++++++++++++
 tb/tb_rambus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rambus_arbiter.sv
// rambus_arbiter: two-master, one-slave Wishbone arbiter in front of the
// rambus SRAM. Master 0 is the spell core, master 1 the host-side bridge.
// Round-robin arbitration; a grant is held for the whole Wishbone cycle
// (while the granted master keeps cyc high). A watchdog aborts a transfer
// whose strobe goes unacknowledged for TIMEOUT_CYCLES cycles, pulses err to
// that master for one cycle and bumps a saturating abort counter.
//
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   m0_* / m1_*               Wishbone slave-side ports for the two masters
//                             (cyc/stb/we/addr/dat/sel in, dat/ack/err out)
//   s_*                       Wishbone master-side port towards the rambus
//   grant_o                   one-hot current grant (01 = m0, 10 = m1, 00 none)
//   timeout_cnt_o             saturating count of watchdog aborts
module rambus_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_dat_i,
  input  logic [3:0]        m0_sel_i,
  output logic [31:0]       m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_dat_i,
  input  logic [3:0]        m1_sel_i,
  output logic [31:0]       m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [31:0]       s_dat_o,
  output logic [3:0]        s_sel_o,
  input  logic [31:0]       s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o,
  output logic [CNT_W-1:0]  timeout_cnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  // The watchdog only has to reach TIMEOUT_CYCLES-1.
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT =
    (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;  // 0 = m0, 1 = m1
  logic [WD_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic [CNT_W-1:0]  timeout_cnt;

  // Granted master's request signals, selected by the registered grant.
  logic              sel_m1;
  logic              mx_cyc, mx_stb, mx_we;
  logic [ADDR_W-1:0] mx_addr;
  logic [31:0]       mx_dat;
  logic [3:0]        mx_sel;

  assign sel_m1  = (state == GNT1);
  assign mx_cyc  = sel_m1 ? m1_cyc_i  : m0_cyc_i;
  assign mx_stb  = sel_m1 ? m1_stb_i  : m0_stb_i;
  assign mx_we   = sel_m1 ? m1_we_i   : m0_we_i;
  assign mx_addr = sel_m1 ? m1_addr_i : m0_addr_i;
  assign mx_dat  = sel_m1 ? m1_dat_i  : m0_dat_i;
  assign mx_sel  = sel_m1 ? m1_sel_i  : m0_sel_i;

  assign timeout_cnt_o = timeout_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      wd_cnt      <= '0;
      timeout_cnt <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wd_cnt     <= wd_cnt_nxt;
      // Counted on entry to ABORT so the new value is visible during ABORT.
      if (state_nxt == ABORT && timeout_cnt != {CNT_W{1'b1}})
        timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wd_cnt_nxt     = '0;
    s_cyc_o        = 1'b0;
    s_stb_o        = 1'b0;
    s_we_o         = 1'b0;
    s_addr_o       = '0;
    s_dat_o        = '0;
    s_sel_o        = '0;
    m0_ack_o       = 1'b0;
    m1_ack_o       = 1'b0;
    m0_err_o       = 1'b0;
    m1_err_o       = 1'b0;
    grant_o        = 2'b00;
    m0_dat_o       = s_dat_i;
    m1_dat_o       = s_dat_i;

    case (state)
      IDLE: begin
        // On contention the master that did not hold the last grant wins.
        if (m0_cyc_i && (!m1_cyc_i || last_grant)) begin
          state_nxt      = GNT0;
          last_grant_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt      = GNT1;
          last_grant_nxt = 1'b1;
        end
      end

      GNT0, GNT1: begin
        grant_o  = sel_m1 ? 2'b10 : 2'b01;
        s_cyc_o  = mx_cyc;
        s_stb_o  = mx_cyc & mx_stb;
        s_we_o   = mx_we;
        s_addr_o = mx_addr;
        s_dat_o  = mx_dat;
        s_sel_o  = mx_sel;
        m0_ack_o = ~sel_m1 & s_ack_i;
        m1_ack_o = sel_m1 & s_ack_i;
        if (!mx_cyc) begin
          state_nxt = IDLE;
        end else if (mx_stb && !s_ack_i && TIMEOUT_CYCLES != 0) begin
          // An ack on the limit cycle takes the else path: no abort.
          if (wd_cnt == WD_LIMIT)
            state_nxt = ABORT;
          else
            wd_cnt_nxt = wd_cnt + WD_W'(1);
        end
      end

      ABORT: begin
        // last_grant still names the aborted master.
        m0_err_o  = ~last_grant;
        m1_err_o  = last_grant;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rambus_arbiter.sv
module tb_rambus_arbiter;
  localparam int ADDR_W = 10;
  localparam int TO     = 4;
  localparam int CNT_W  = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [31:0]       m0_dat_i;
  logic [3:0]        m0_sel_i;
  logic [31:0]       m0_dat_o;
  logic              m0_ack_o, m0_err_o;
  logic              m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [31:0]       m1_dat_i;
  logic [3:0]        m1_sel_i;
  logic [31:0]       m1_dat_o;
  logic              m1_ack_o, m1_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [31:0]       s_dat_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_dat_i;
  logic              s_ack_i;
  logic [1:0]        grant_o;
  logic [CNT_W-1:0]  timeout_cnt_o;

  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;

  int checks   = 0;
  int failures = 0;

  rambus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clock = ~clock;

  // Slave: optional auto-ack of every strobe, plus a manual ack for directed cases.
  assign s_ack_i = man_ack | (auto_ack & s_cyc_o & s_stb_o);
  assign s_dat_i = 32'hA5C3_0000 | 32'(s_addr_o);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int owner      = -1;  // master currently owning the bus, -1 none
  int aborted_by = -1;  // master being reported in the abort cycle, -1 none
  int last_m     = 1;   // master of the most recent grant
  int stall      = 0;   // consecutive unacknowledged strobe cycles
  int tcnt_m     = 0;

  function automatic logic own_cyc(input int k);
    return (k == 1) ? m1_cyc_i : m0_cyc_i;
  endfunction
  function automatic logic own_stb(input int k);
    return (k == 1) ? m1_stb_i : m0_stb_i;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner <= -1; aborted_by <= -1; last_m <= 1; stall <= 0; tcnt_m <= 0;
    end else if (aborted_by >= 0) begin
      aborted_by <= -1;
    end else if (owner < 0) begin
      stall <= 0;
      if (m0_cyc_i && m1_cyc_i) begin
        owner  <= 1 - last_m;
        last_m <= 1 - last_m;
      end else if (m0_cyc_i) begin
        owner <= 0; last_m <= 0;
      end else if (m1_cyc_i) begin
        owner <= 1; last_m <= 1;
      end
    end else if (!own_cyc(owner)) begin
      owner <= -1; stall <= 0;
    end else if (own_stb(owner) && !s_ack_i) begin
      if (TO != 0 && stall + 1 >= TO) begin
        aborted_by <= owner;
        owner      <= -1;
        stall      <= 0;
        tcnt_m     <= (tcnt_m >= (1 << CNT_W) - 1) ? tcnt_m : tcnt_m + 1;
      end else begin
        stall <= stall + 1;
      end
    end else begin
      stall <= 0;
    end
  end

  logic [1:0]        e_grant;
  logic              e_cyc, e_stb, e_we, e_ack0, e_ack1, e_err0, e_err1;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_dat;
  logic [3:0]        e_sel;

  always @(negedge clock) begin
    e_grant = 2'b00; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_addr = '0; e_dat = '0; e_sel = '0;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
    if (owner == 0) begin
      e_grant = 2'b01; e_cyc = m0_cyc_i; e_stb = m0_cyc_i & m0_stb_i; e_we = m0_we_i;
      e_addr = m0_addr_i; e_dat = m0_dat_i; e_sel = m0_sel_i; e_ack0 = s_ack_i;
    end else if (owner == 1) begin
      e_grant = 2'b10; e_cyc = m1_cyc_i; e_stb = m1_cyc_i & m1_stb_i; e_we = m1_we_i;
      e_addr = m1_addr_i; e_dat = m1_dat_i; e_sel = m1_sel_i; e_ack1 = s_ack_i;
    end else if (aborted_by == 0) begin
      e_err0 = 1'b1;
    end else if (aborted_by == 1) begin
      e_err1 = 1'b1;
    end
    chk("cyc_grant", {grant_o, s_cyc_o, s_stb_o, s_we_o}, {e_grant, e_cyc, e_stb, e_we});
    chk("addr_sel", {s_addr_o, s_sel_o}, {e_addr, e_sel});
    chk("wdata", s_dat_o, e_dat);
    chk("ack_err", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, {e_ack0, e_ack1, e_err0, e_err1});
    chk("rdata", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
    chk("tcnt", timeout_cnt_o, tcnt_m[CNT_W-1:0]);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_masters();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL run_time_bound actual=expired required=finished");
    $fatal(1, "time bound");
  end

  initial begin
    idle_masters();
    #1;
    chk("lit_reset_grant", grant_o, 2'b00);
    chk("lit_reset_scyc", s_cyc_o, 1'b0);
    chk("lit_reset_tcnt", timeout_cnt_o, 2'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single m0 write
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_addr_i = 10'h005;
    m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF;
    #1 chk("lit_latency_scyc", s_cyc_o, 1'b0);
    tick();
    chk("lit_w_grant", grant_o, 2'b01);
    chk("lit_w_scyc", s_cyc_o, 1'b1);
    chk("lit_w_addr", s_addr_o, 10'h005);
    chk("lit_w_data", s_dat_o, 32'hDEADBEEF);
    man_ack = 1;
    #1 chk("lit_w_ack", {m0_ack_o, m1_ack_o}, 2'b10);
    tick();
    man_ack = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    #1 chk("lit_release_comb", {grant_o, s_cyc_o}, 3'b010);
    tick();
    chk("lit_release_grant", grant_o, 2'b00);

    // Contention straight after reset: m0 first, one bubble, then m1
    reset_n = 0; tick(); reset_n = 1; tick();
    auto_ack = 1;
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 10'h007;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 10'h009;
    tick();
    chk("lit_c_grant0", grant_o, 2'b01);
    chk("lit_c_acks", {m0_ack_o, m1_ack_o}, 2'b10);
    chk("lit_c_rdata", m0_dat_o, 32'hA5C3_0007);
    tick();
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    chk("lit_c_bubble", grant_o, 2'b00);
    tick();
    chk("lit_c_grant1", grant_o, 2'b10);
    chk("lit_c_ack1", m1_ack_o, 1'b1);
    m1_cyc_i = 0; m1_stb_i = 0;
    tick();

    // m1 burst of three reads with stb toggling while m0 waits
    m1_cyc_i = 1; m1_stb_i = 0;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 10'h003;
    for (int i = 0; i < 3; i++) begin
      m1_addr_i = 10'h010 + 10'(i); m1_stb_i = 1;
      #1 chk("lit_b_ack", {grant_o, m1_ack_o, m0_ack_o}, 4'b1010);
      chk("lit_b_rdata", m1_dat_o, 32'hA5C3_0010 + 32'(i));
      tick();
      m1_stb_i = 0;
      tick();
      chk("lit_b_hold", grant_o, 2'b10);
    end
    m1_cyc_i = 0;
    tick();
    chk("lit_b_bubble", grant_o, 2'b00);
    tick();
    chk("lit_b_m0", grant_o, 2'b01);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    auto_ack = 0;

    // Watchdog abort of m0
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 10'h021;
    tick();
    tick(); tick(); tick();
    chk("lit_t_pre", {grant_o, m0_err_o}, 3'b010);
    tick();
    chk("lit_t_abort", {grant_o, s_cyc_o, m0_err_o, m0_ack_o, m1_err_o}, 6'b000100);
    chk("lit_t_cnt", timeout_cnt_o, 2'd1);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    chk("lit_t_after", {grant_o, m0_err_o}, 3'b000);
    // Aborted master loses the next contended arbitration
    auto_ack = 1;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    chk("lit_t_prio", grant_o, 2'b10);
    m1_cyc_i = 0; m1_stb_i = 0;
    tick(); tick();
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    auto_ack = 0;

    // Ack on the limit cycle wins over the abort
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    tick(); tick(); tick();
    man_ack = 1;
    #1 chk("lit_l_ack", {m0_ack_o, m0_err_o}, 2'b10);
    tick();
    man_ack = 0;
    chk("lit_l_hold", {grant_o, m0_err_o, timeout_cnt_o}, {2'b01, 1'b0, 2'd1});
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();

    // Spurious slave ack while idle
    man_ack = 1;
    #1 chk("lit_spurious", {m0_ack_o, m1_ack_o}, 2'b00);
    tick();
    man_ack = 0;

    // Three m1 aborts: counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      m1_cyc_i = 1; m1_stb_i = 1;
      tick();
      tick(); tick(); tick(); tick();
      chk("lit_s_err1", {m1_err_o, m0_err_o}, 2'b10);
      m1_cyc_i = 0; m1_stb_i = 0;
      tick();
    end
    chk("lit_s_sat", timeout_cnt_o, 2'd3);

    // Asynchronous reset in the middle of an m1 grant
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 10'h0AA;
    tick();
    chk("lit_r_pre", grant_o, 2'b10);
    reset_n = 0;
    #1 chk("lit_r_async", {grant_o, s_cyc_o, m1_ack_o, m1_err_o, timeout_cnt_o}, 7'd0);
    idle_masters();
    tick();
    reset_n = 1;
    tick();
    auto_ack = 1;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    chk("lit_r_first", grant_o, 2'b01);
    idle_masters();
    auto_ack = 0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
